// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU core and its nibble-serial sequencer:
// opcode constants, op-class and FSM state enums.
package alu4_pkg;

    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_ASR = 4'd11;
    localparam logic [3:0] OP_SHL = 4'd12;
    localparam logic [3:0] OP_SHR = 4'd13;
    localparam logic [3:0] OP_RCL = 4'd14;
    localparam logic [3:0] OP_RCR = 4'd15;

    // Second-step opcodes for the two-nibble shifts: rotate through carry
    localparam logic [3:0] CONT_SHL = OP_RCL;
    localparam logic [3:0] CONT_SHR = OP_RCR;

    typedef enum logic [1:0] {
        CLS_ADDC,
        CLS_SHL,
        CLS_SHR,
        CLS_INDEP
    } op_class_t;

    typedef enum logic [1:0] {
        IDLE,
        STEP1,
        STEP2
    } state_t;

endpackage

// File: rtl/alu4_op_class.sv
// Opcode classifier: decides carry chaining, second-step opcode and nibble order.
module alu4_op_class
    import alu4_pkg::*;
(
    input  logic [3:0] op,
    output op_class_t  op_class,
    output logic [3:0] cont_op,
    output logic       high_first
);

    always_comb begin
        op_class   = CLS_INDEP;
        cont_op    = op;
        high_first = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                op_class = CLS_ADDC;
            end
            OP_SHL, OP_RCL: begin
                op_class = CLS_SHL;
                cont_op  = CONT_SHL;
            end
            OP_ASR, OP_SHR, OP_RCR: begin
                op_class   = CLS_SHR;
                cont_op    = CONT_SHR;
                high_first = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu4_byte_sequencer.sv
// Nibble-serial initiator: runs one 8-bit operation on the 4-bit ALU core as
// two steps, chaining math or rotate carry, and assembles result and flags.
//
// state | meaning
// IDLE  | waiting for start, alu_* held at 0
// STEP1 | first nibble on the ALU, its result captured at the edge
// STEP2 | second nibble on the ALU, result/flags updated at the edge
module alu4_byte_sequencer
    import alu4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    input  logic       rot_carry_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       math_carry_out,
    output logic       rot_carry_out,
    output logic       overflow,
    output logic       zero,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_math_cin,
    output logic       alu_rot_cin,
    input  logic [3:0] alu_out,
    input  logic       alu_math_cout,
    input  logic       alu_rot_cout,
    input  logic       alu_overflow
);

    state_t     state, state_d;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q;
    logic       cin_q, rcin_q;
    logic [3:0] nib1_q;
    logic       mc1_q, rc1_q, ov1_q;

    op_class_t  op_class;
    logic [3:0] cont_op;
    logic       high_first;

    alu4_op_class u_op_class (
        .op         (op_q),
        .op_class   (op_class),
        .cont_op    (cont_op),
        .high_first (high_first)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = STEP1;
            STEP1:   state_d = STEP2;
            STEP2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        alu_op       = 4'd0;
        alu_a        = 4'd0;
        alu_b        = 4'd0;
        alu_math_cin = 1'b0;
        alu_rot_cin  = 1'b0;
        case (state)
            STEP1: begin
                busy         = 1'b1;
                alu_op       = op_q;
                alu_a        = high_first ? a_q[7:4] : a_q[3:0];
                alu_b        = high_first ? b_q[7:4] : b_q[3:0];
                alu_math_cin = cin_q;
                alu_rot_cin  = rcin_q;
            end
            STEP2: begin
                busy         = 1'b1;
                alu_op       = cont_op;
                alu_a        = high_first ? a_q[3:0] : a_q[7:4];
                alu_b        = high_first ? b_q[3:0] : b_q[7:4];
                alu_math_cin = (op_class == CLS_ADDC) ? mc1_q : cin_q;
                alu_rot_cin  = (op_class == CLS_SHL || op_class == CLS_SHR) ? rc1_q : rcin_q;
            end
            default: ;
        endcase
    end

    // Operand latch, step-1 capture and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= 4'd0;
            a_q            <= 8'd0;
            b_q            <= 8'd0;
            cin_q          <= 1'b0;
            rcin_q         <= 1'b0;
            nib1_q         <= 4'd0;
            mc1_q          <= 1'b0;
            rc1_q          <= 1'b0;
            ov1_q          <= 1'b0;
            done           <= 1'b0;
            result         <= 8'd0;
            math_carry_out <= 1'b0;
            rot_carry_out  <= 1'b0;
            overflow       <= 1'b0;
            zero           <= 1'b0;
        end else begin
            done <= (state == STEP2);
            if (state == IDLE && start) begin
                op_q   <= op;
                a_q    <= a;
                b_q    <= b;
                cin_q  <= carry_in;
                rcin_q <= rot_carry_in;
            end
            if (state == STEP1) begin
                nib1_q <= alu_out;
                mc1_q  <= alu_math_cout;
                rc1_q  <= alu_rot_cout;
                ov1_q  <= alu_overflow;
            end
            if (state == STEP2) begin
                result         <= high_first ? {nib1_q, alu_out} : {alu_out, nib1_q};
                math_carry_out <= high_first ? mc1_q : alu_math_cout;
                overflow       <= high_first ? ov1_q : alu_overflow;
                rot_carry_out  <= alu_rot_cout;
                zero           <= (nib1_q == 4'd0) && (alu_out == 4'd0);
            end
        end
    end

endmodule

// File: doc/alu4_byte_sequencer.md
# alu4_byte_sequencer

- Nibble-serial initiator for the 4-bit ALU core.
- Accepts one 8-bit operation with a start/busy/done handshake.
- Issues the operation to the ALU as two nibble steps, chaining math carry or rotate carry between the steps.
- Assembles the 8-bit result and flags. Sits between the tile I/O glue and the combinational ALU core, whose operand, opcode and carry inputs it drives.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; accepted only while busy=0.
- op  in  4  ALU opcode (0–15).
- a, b  in  8  operands.
- carry_in, rot_carry_in  in  1  external math and rotate carry.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when results are valid.
- result  out  8  assembled result; held until the next done.
- math_carry_out, rot_carry_out, overflow, zero  out  1  flags; held with result.
- alu_op  out  4  opcode driven to the ALU core.
- alu_a, alu_b  out  4  nibble operands driven to the ALU core.
- alu_math_cin, alu_rot_cin  out  1  carries driven to the ALU core.
- alu_out  in  4  ALU result nibble; combinational from alu_*.
- alu_math_cout, alu_rot_cout, alu_overflow  in  1  ALU flags.

## Operation
Opcode classes:
- ADDC {4,5}: low nibble first.
  - Step 1: external carry_in.
  - Step 2: same op; alu_math_cin = step-1 alu_math_cout.
- SHL {12,14}: low nibble first.
  - Step 1: op as given; alu_rot_cin = rot_carry_in.
  - Step 2: op 14; alu_rot_cin = step-1 alu_rot_cout.
- SHR {11,13,15}: high nibble first.
  - Step 1: op as given; alu_rot_cin = rot_carry_in.
  - Step 2: op 15; alu_rot_cin = step-1 alu_rot_cout.
- INDEP (all others): low nibble first; both steps use the same op with external carries; no chaining.

Flag assembly:
- math_carry_out and overflow come from the high-nibble step.
- rot_carry_out comes from step 2.
- zero = 1 iff both captured nibbles are 0.

FSM states: IDLE, STEP1, STEP2.
- IDLE: start=1 → latch op, a, b, carry_in, rot_carry_in → STEP1. Otherwise stay.
- STEP1: alu_* driven from the latched values. At the edge, capture alu_out and carries → STEP2.
- STEP2: capture, update result/flags, assert done next cycle → IDLE.

Rules:
- busy=1 in STEP1 and STEP2.
- In IDLE, all alu_* outputs are 0.
- start while busy is ignored, not queued.
- Input changes after acceptance have no effect.

## Timing
- Start sampled high at edge N (IDLE) → STEP1 during N..N+1 → STEP2 during N+1..N+2 → done=1 for cycle N+2..N+3.
- Latency is 3 cycles from start to done. Throughput is one operation per 3 cycles.
- done and a new start in the same cycle: start is accepted, because the state is already IDLE.
- alu_* outputs are combinational from state plus latched registers. The ALU path must close within one cycle.
- Reset values: busy=0, done=0, result=0x00, all flags 0, state IDLE, alu_* = 0.
- Reset mid-operation: abort to IDLE next edge; no done pulse; outputs cleared.
- Operand widths:
  - Only 4-bit nibbles go to the ALU.
  - No 8-bit arithmetic is performed in this block.
  - Carry beyond bit 7 appears only in math_carry_out.

## Structure
- Package alu4_pkg holds:
  - opcode constants, including OP_SHL=12, OP_RCL=14, OP_ASR=11, OP_SHR=13, OP_RCR=15, OP_ADD=4, OP_SUB=5;
  - the op-class enum (ADDC, SHL, SHR, INDEP);
  - the FSM state enum;
  - continuation opcode constants (14, 15).
- Sub-module alu4_op_class: combinational op → {class, continuation op, high-first}. It is shared with the future microcode decoder.
- The ALU core is not instantiated inside this block. It is wired alongside at the top level.

## Test plan
- op=4, a=0x3C, b=0x5A, carry_in=0 → result=0x96, math_carry_out=0, overflow=1, zero=0; done exactly 3 cycles after start.
- op=5, a=0x50, b=0x21, carry_in=1 → result=0x2F, math_carry_out=1, overflow=0.
- op=12, a=0x96 → result=0x2C, rot_carry_out=1. op=11, a=0x96 → result=0xCB, rot_carry_out=0.
- op=15, a=0x01, rot_carry_in=1 → result=0x80, rot_carry_out=1. op=14, a=0x80, rot_carry_in=0 → result=0x00, rot_carry_out=1, zero=1.
- Handshake:
  - start pulsed during STEP1 → ignored; only one done pulse, with results for the first op.
  - start held high continuously → back-to-back ops, done every 3 cycles.
- rst asserted in STEP2 → next cycle busy=0, result=0x00, no done pulse, all alu_* = 0.
